// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex UART transceiver with a runtime bit-period divider.
//   TX serialises tx_data (LSB first) onto utxd behind a valid/ready handshake.
//   RX synchronises urxd, samples mid-bit, and presents rx_data with error
//   flags behind a valid/ready handshake.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   baud_div        clocks per bit minus 1 (values below 3 act as 3)
//   tx_data/valid   parallel word to send; tx_ready high when TX idle
//   tx_busy         TX frame in progress
//   utxd            serial output, idle high
//   urxd            serial input, asynchronous to clk
//   rx_data/valid   received word, held until rx_ready
//   rx_parity_err   parity mismatch, qualified by rx_valid
//   rx_frame_err    stop bit sampled low, qualified by rx_valid
//   rx_overrun      sticky: a frame was dropped while rx_valid was held
//   rx_busy         RX frame in progress
module uart_txrx #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              utxd,
    input  logic              urxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_busy
);

    localparam int unsigned BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = (PARITY != 0);
    localparam logic        ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // Parity bit that accompanies a data word.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ODD_PARITY ? ~^d : ^d;
    endfunction

    // Clamp tiny divisors so mid-bit sampling stays meaningful.
    logic [DIV_W-1:0] eff_div;
    assign eff_div = (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;

    // ------------------------------------------------------------------ TX
    tx_state_t         tx_state, tx_state_nxt;
    logic [DIV_W-1:0]  tx_cnt, tx_cnt_nxt;
    logic [DIV_W-1:0]  tx_div, tx_div_nxt;
    logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
    logic [BIT_W-1:0]  tx_bit, tx_bit_nxt;
    logic              tx_stop, tx_stop_nxt;
    logic              tx_par, tx_par_nxt;
    logic              utxd_nxt, tx_ready_nxt;
    logic              tx_tick;

    // TX state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_par   <= 1'b0;
            utxd     <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_div   <= tx_div_nxt;
            tx_shift <= tx_shift_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_stop  <= tx_stop_nxt;
            tx_par   <= tx_par_nxt;
            utxd     <= utxd_nxt;
            tx_ready <= tx_ready_nxt;
            tx_busy  <= ~tx_ready_nxt;
        end
    end

    // TX next state: each state holds for tx_div+1 clocks, counted down to 0.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_div_nxt   = tx_div;
        tx_shift_nxt = tx_shift;
        tx_bit_nxt   = tx_bit;
        tx_stop_nxt  = tx_stop;
        tx_par_nxt   = tx_par;
        utxd_nxt     = utxd;
        tx_ready_nxt = tx_ready;
        tx_tick      = (tx_cnt == '0);
        tx_cnt_nxt   = tx_tick ? tx_div : tx_cnt - DIV_W'(1);

        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt   = tx_cnt;
                utxd_nxt     = 1'b1;
                tx_ready_nxt = 1'b1;
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = tx_data;
                    tx_par_nxt   = parity_of(tx_data);
                    tx_div_nxt   = eff_div;
                    tx_cnt_nxt   = eff_div;
                    utxd_nxt     = 1'b0;
                    tx_ready_nxt = 1'b0;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_nxt = TX_DATA;
                    tx_bit_nxt   = '0;
                    utxd_nxt     = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            tx_state_nxt = TX_PARITY;
                            utxd_nxt     = tx_par;
                        end else begin
                            tx_state_nxt = TX_STOP;
                            tx_stop_nxt  = 1'b0;
                            utxd_nxt     = 1'b1;
                        end
                    end else begin
                        tx_bit_nxt   = tx_bit + BIT_W'(1);
                        tx_shift_nxt = {1'b0, tx_shift[DATA_W-1:1]};
                        utxd_nxt     = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_nxt = TX_STOP;
                    tx_stop_nxt  = 1'b0;
                    utxd_nxt     = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_stop == LAST_STOP) begin
                        tx_state_nxt = TX_IDLE;
                        tx_ready_nxt = 1'b1;
                    end else begin
                        tx_stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                utxd_nxt     = 1'b1;
                tx_ready_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------ RX
    rx_state_t         rx_state, rx_state_nxt;
    logic              urxd_meta, urxd_s;
    logic [DIV_W-1:0]  rx_cnt, rx_cnt_nxt;
    logic [DIV_W-1:0]  rx_div, rx_div_nxt;
    logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
    logic [BIT_W-1:0]  rx_bit, rx_bit_nxt;
    logic              frame_perr, frame_perr_nxt;
    logic              frame_ferr, frame_ferr_nxt;
    logic              rx_pend, rx_pend_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt, rx_parity_err_nxt, rx_frame_err_nxt;
    logic              rx_overrun_nxt;
    logic              rx_tick;

    // RX synchroniser, state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            urxd_meta     <= 1'b1;
            urxd_s        <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_div        <= '0;
            rx_shift      <= '0;
            rx_bit        <= '0;
            frame_perr    <= 1'b0;
            frame_ferr    <= 1'b0;
            rx_pend       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            urxd_meta     <= urxd;
            urxd_s        <= urxd_meta;
            rx_state      <= rx_state_nxt;
            rx_cnt        <= rx_cnt_nxt;
            rx_div        <= rx_div_nxt;
            rx_shift      <= rx_shift_nxt;
            rx_bit        <= rx_bit_nxt;
            frame_perr    <= frame_perr_nxt;
            frame_ferr    <= frame_ferr_nxt;
            rx_pend       <= rx_pend_nxt;
            rx_data       <= rx_data_nxt;
            rx_valid      <= rx_valid_nxt;
            rx_parity_err <= rx_parity_err_nxt;
            rx_frame_err  <= rx_frame_err_nxt;
            rx_overrun    <= rx_overrun_nxt;
            rx_busy       <= (rx_state_nxt != RX_IDLE);
        end
    end

    // RX next state plus delivery of a finished frame one cycle after its stop sample.
    always_comb begin
        rx_state_nxt      = rx_state;
        rx_div_nxt        = rx_div;
        rx_shift_nxt      = rx_shift;
        rx_bit_nxt        = rx_bit;
        frame_perr_nxt    = frame_perr;
        frame_ferr_nxt    = frame_ferr;
        rx_pend_nxt       = 1'b0;
        rx_data_nxt       = rx_data;
        rx_valid_nxt      = rx_valid;
        rx_parity_err_nxt = rx_parity_err;
        rx_frame_err_nxt  = rx_frame_err;
        rx_overrun_nxt    = rx_overrun;
        rx_tick           = (rx_cnt == '0);
        rx_cnt_nxt        = rx_tick ? rx_div : rx_cnt - DIV_W'(1);

        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = rx_cnt;
                if (!urxd_s) begin
                    // Half-period countdown puts every later sample mid-bit.
                    rx_state_nxt   = RX_START;
                    rx_div_nxt     = eff_div;
                    rx_cnt_nxt     = eff_div >> 1;
                    frame_perr_nxt = 1'b0;
                    frame_ferr_nxt = 1'b0;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (urxd_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_bit_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_nxt = {urxd_s, rx_shift[DATA_W-1:1]};
                    if (rx_bit == LAST_BIT) begin
                        rx_state_nxt = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    frame_perr_nxt = urxd_s ^ parity_of(rx_shift);
                    rx_state_nxt   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    frame_ferr_nxt = ~urxd_s;
                    rx_pend_nxt    = 1'b1;
                    rx_state_nxt   = urxd_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                rx_cnt_nxt = rx_cnt;
                if (urxd_s) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase

        if (rx_pend) begin
            if (!rx_valid || rx_ready) begin
                rx_data_nxt       = rx_shift;
                rx_parity_err_nxt = frame_perr;
                rx_frame_err_nxt  = frame_ferr;
                rx_valid_nxt      = 1'b1;
                rx_overrun_nxt    = 1'b0;
            end else begin
                rx_overrun_nxt = 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid_nxt   = 1'b0;
            rx_overrun_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: an 8N1 instance for TX waveform and reset checks and an
// 8E1 instance for loopback and hand-driven RX frames. Expected RX words are
// queued when stimulus is issued; a monitor pops them on each rx handshake.
module tb_uart_txrx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;
    localparam int          P      = 16;

    logic clk = 1'b0;
    logic rst;
    logic [DIV_W-1:0] baud_div = DIV_W'(15);

    always #5 clk = ~clk;

    // 8N1 instance
    logic [DATA_W-1:0] tx_data_n, rx_data_n;
    logic tx_valid_n, tx_ready_n, tx_busy_n, utxd_n;
    logic urxd_n = 1'b1;
    logic rx_ready_n = 1'b1;
    logic rx_valid_n, rx_parity_err_n, rx_frame_err_n, rx_overrun_n, rx_busy_n;

    // 8E1 instance
    logic [DATA_W-1:0] tx_data_e, rx_data_e;
    logic tx_valid_e, tx_ready_e, tx_busy_e, utxd_e, urxd_e;
    logic rx_ready_e, line_e, loop_en;
    logic rx_valid_e, rx_parity_err_e, rx_frame_err_e, rx_overrun_e, rx_busy_e;

    assign urxd_e = loop_en ? utxd_e : line_e;

    uart_txrx #(.DATA_W(DATA_W), .PARITY(0), .STOP_BITS(1), .DIV_W(DIV_W)) dut_n (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .tx_busy(tx_busy_n), .utxd(utxd_n), .urxd(urxd_n),
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
        .rx_parity_err(rx_parity_err_n), .rx_frame_err(rx_frame_err_n),
        .rx_overrun(rx_overrun_n), .rx_busy(rx_busy_n)
    );

    uart_txrx #(.DATA_W(DATA_W), .PARITY(1), .STOP_BITS(1), .DIV_W(DIV_W)) dut_e (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .tx_busy(tx_busy_e), .utxd(utxd_e), .urxd(urxd_e),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
        .rx_parity_err(rx_parity_err_e), .rx_frame_err(rx_frame_err_e),
        .rx_overrun(rx_overrun_e), .rx_busy(rx_busy_e)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        return e;
    endfunction

    // Scoreboard monitor: every accepted RX word must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rx_valid_e && rx_ready_e) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got word %02h, expected none", rx_data_e);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data_e), 32'(e.data));
                check("rx_parity_err", 32'(rx_parity_err_e), 32'(e.perr));
                check("rx_frame_err", 32'(rx_frame_err_e), 32'(e.ferr));
            end
        end
    end

    // Advance n clocks, leaving time 1 unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hand the 8E1 transmitter one word, waiting (bounded) for tx_ready.
    task automatic tx_send_e(input logic [7:0] d);
        int b = 0;
        tx_data_e  = d;
        tx_valid_e = 1'b1;
        while (!tx_ready_e && b < 2000) begin
            tick(1);
            b++;
        end
        check("tx_ready_wait", 32'(tx_ready_e), 32'h1);
        tick(1);
        tx_valid_e = 1'b0;
    endtask

    // Drive one 8E1 frame on urxd_e; stop_low>0 holds the stop bit low that many periods.
    task automatic drive_frame(input logic [7:0] d, input logic pbit, input int stop_low);
        line_e = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            line_e = d[i];
            tick(P);
        end
        line_e = pbit;
        tick(P);
        if (stop_low > 0) begin
            line_e = 1'b0;
            tick(stop_low * P);
        end
        line_e = 1'b1;
        tick(2 * P);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            tick(1);
            b++;
        end
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] exp_bits;
        logic       ok;

        rst        = 1'b1;
        tx_data_n  = '0;
        tx_valid_n = 1'b0;
        tx_data_e  = '0;
        tx_valid_e = 1'b0;
        rx_ready_e = 1'b1;
        line_e     = 1'b1;
        loop_en    = 1'b0;
        tick(3);

        // Reset values
        check("rst_utxd", 32'(utxd_e), 32'h1);
        check("rst_tx_ready", 32'(tx_ready_e), 32'h1);
        check("rst_tx_busy", 32'(tx_busy_e), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_e), 32'h0);
        check("rst_rx_data", 32'(rx_data_e), 32'h0);
        check("rst_rx_busy", 32'(rx_busy_e), 32'h0);
        check("rst_rx_overrun", 32'(rx_overrun_e), 32'h0);
        check("rst_utxd_n", 32'(utxd_n), 32'h1);
        rst = 1'b0;
        tick(4);

        // 8N1 0xA5: start, LSB-first data, stop; 16 clocks per bit, 160 clocks busy
        exp_bits   = {1'b1, 8'hA5, 1'b0};
        tx_data_n  = 8'hA5;
        tx_valid_n = 1'b1;
        tick(1);
        tx_valid_n = 1'b0;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int k = 0; k < P; k++) begin
                if (utxd_n !== exp_bits[b] || tx_ready_n !== 1'b0 || tx_busy_n !== 1'b1)
                    ok = 1'b0;
                tick(1);
            end
            check($sformatf("tx_bit%0d", b), 32'(ok), 32'h1);
        end
        check("tx_ready_after_frame", 32'(tx_ready_n), 32'h1);
        check("tx_busy_after_frame", 32'(tx_busy_n), 32'h0);
        check("utxd_idle_after_frame", 32'(utxd_n), 32'h1);

        // Loopback, even parity, back-to-back words
        loop_en = 1'b1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
        tx_send_e(8'h00);
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0));
        tx_send_e(8'hFF);
        exp_q.push_back(mk(8'h5A, 1'b0, 1'b0));
        tx_send_e(8'h5A);
        wait_drain("loopback_drain", 2000);
        tick(2 * P);
        loop_en = 1'b0;
        tick(2);

        // 0x01 with wrong even-parity bit
        exp_q.push_back(mk(8'h01, 1'b1, 1'b0));
        drive_frame(8'h01, 1'b0, 0);
        wait_drain("parity_err_drain", 200);

        // Stop held low for 3 periods, then a clean frame
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b1));
        drive_frame(8'h3C, 1'b0, 3);
        exp_q.push_back(mk(8'hC3, 1'b0, 1'b0));
        drive_frame(8'hC3, 1'b0, 0);
        wait_drain("frame_err_drain", 200);

        // Overrun: second word dropped while the first is held
        rx_ready_e = 1'b0;
        exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
        drive_frame(8'h11, 1'b0, 0);
        drive_frame(8'h22, 1'b0, 0);
        tick(4);
        check("ovr_rx_valid", 32'(rx_valid_e), 32'h1);
        check("ovr_rx_data", 32'(rx_data_e), 32'h11);
        check("ovr_rx_overrun", 32'(rx_overrun_e), 32'h1);
        rx_ready_e = 1'b1;
        tick(2);
        check("ovr_clear_valid", 32'(rx_valid_e), 32'h0);
        check("ovr_clear_overrun", 32'(rx_overrun_e), 32'h0);
        wait_drain("overrun_drain", 50);

        // 4-clock glitch is rejected as a false start
        line_e = 1'b0;
        tick(4);
        line_e = 1'b1;
        tick(3 * P);
        check("glitch_rx_valid", 32'(rx_valid_e), 32'h0);
        check("glitch_rx_busy", 32'(rx_busy_e), 32'h0);

        // Reset in the middle of a TX frame
        tx_data_n  = 8'h00;
        tx_valid_n = 1'b1;
        tick(1);
        tx_valid_n = 1'b0;
        tick(40);
        check("mid_tx_utxd", 32'(utxd_n), 32'h0);
        check("mid_tx_ready", 32'(tx_ready_n), 32'h0);
        rst = 1'b1;
        #1;
        check("abort_utxd", 32'(utxd_n), 32'h1);
        check("abort_tx_ready", 32'(tx_ready_n), 32'h1);
        check("abort_tx_busy", 32'(tx_busy_n), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(12 * P);
        check("post_abort_utxd", 32'(utxd_n), 32'h1);
        check("post_abort_tx_ready", 32'(tx_ready_n), 32'h1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
